// File: rtl/qlab5_sys_gpio.sv
// qlab5_sys_gpio: Avalon-MM GPIO with output/direction registers, input synchronizer and
// optional edge capture + interrupt (enabled by defining QLAB5_GPIO_EDGE_CAPTURE_EN).
module qlab5_sys_gpio #(
  parameter int WIDTH       = 8,
  parameter int RESET_VALUE = 0,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);
  logic [WIDTH-1:0] data_out, dir, sync_in, wd, rd, irq_mask, edgecap;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [31:0]      unused_wd;
  logic             we;
  assign we        = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = writedata;
  assign sync_in   = sync_q[SYNC_STAGES-1];
  assign out_port  = data_out;
  assign oe        = dir;
  assign irq       = |(edgecap & irq_mask);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out <= WIDTH'(RESET_VALUE);
      dir      <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      if (we && address == 3'd0) data_out <= wd;
      else if (we && address == 3'd4) data_out <= data_out | wd;
      else if (we && address == 3'd5) data_out <= data_out & ~wd;
      if (we && address == 3'd1) dir <= wd;
    end
  end
`ifdef QLAB5_GPIO_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] sync_prev, det;
  logic [2:0]       blank;
  // Capture is held off until the synchronizer has flushed the pin state present at reset release.
  assign det = (blank != 3'd0) ? '0 :
               (EDGE_TYPE == 0) ? sync_in & ~sync_prev :
               (EDGE_TYPE == 1) ? ~sync_in & sync_prev : sync_in ^ sync_prev;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_prev <= '0;
      edgecap   <= '0;
      irq_mask  <= '0;
      blank     <= 3'(SYNC_STAGES + 1);
    end else begin
      sync_prev <= sync_in;
      if (blank != 3'd0) blank <= blank - 3'd1;
      if (we && address == 3'd2) irq_mask <= wd;
      edgecap <= (edgecap & ~((we && address == 3'd3) ? wd : '0)) | det;
    end
  end
`else
  logic [1:0] unused_edge_type;
  assign unused_edge_type = 2'(EDGE_TYPE);
  assign irq_mask = '0;
  assign edgecap  = '0;
`endif
  always_comb begin
    rd = (address == 3'd0) ? (data_out & dir) | (sync_in & ~dir) :
         (address == 3'd1) ? dir :
         (address == 3'd2) ? irq_mask :
         (address == 3'd3) ? edgecap : '0;
  end
  assign readdata = 32'(rd);
endmodule

// File: tb/tb_qlab5_sys_gpio.sv
// tb_qlab5_sys_gpio: directed scoreboard bench for qlab5_sys_gpio (both macro builds).
module tb_qlab5_sys_gpio;
  logic        clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [2:0]  address = 0;
  logic [31:0] writedata = 0, readdata;
  logic [7:0]  in_port = 0, out_port, oe;
  logic        irq;
  int          checks = 0, fails = 0;
  logic [1:0]  kq[$];
  logic [31:0] eq[$];
  string       nq[$];

  qlab5_sys_gpio #(.WIDTH(8), .RESET_VALUE(32'h15A), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .in_port(in_port),
    .out_port(out_port), .oe(oe), .irq(irq)
  );

  always #5 clk = ~clk;

  // kinds: 0 readdata, 1 out_port, 2 oe, 3 irq
  always @(negedge clk) begin
    logic [1:0]  k;
    logic [31:0] e, a;
    string       n;
    while (kq.size() > 0) begin
      k = kq.pop_front(); e = eq.pop_front(); n = nq.pop_front();
      a = (k == 2'd0) ? readdata : (k == 2'd1) ? 32'(out_port) : (k == 2'd2) ? 32'(oe) : 32'(irq);
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
`ifndef QLAB5_GPIO_EDGE_CAPTURE_EN
    checks++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_const: got %b expected 0", irq);
    end
`endif
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic expect_v(input logic [1:0] k, input logic [31:0] e, input string n);
    kq.push_back(k); eq.push_back(e); nq.push_back(n);
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    step();
    chipselect = 0; write_n = 1;
  endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    address = a; chipselect = 1; write_n = 1;
    expect_v(2'd0, e, n);
    step();
    chipselect = 0;
  endtask

  initial begin
    // write during reset must be discarded
    chipselect = 1; write_n = 0; address = 3'd1; writedata = 32'hFF;
    step();
    chipselect = 0; write_n = 1;
    expect_v(2'd1, 32'h5A, "rst_out_port");
    expect_v(2'd2, 32'h00, "rst_oe");
    expect_v(2'd3, 32'h0, "rst_irq");
    step();
    reset_n = 1;
    step();
    rd(3'd1, 32'h0, "rst_dir");
    rd(3'd0, 32'h0, "rst_mixed");
    wr(3'd0, 32'hA5); expect_v(2'd1, 32'hA5, "load_a5");
    wr(3'd4, 32'h0F); expect_v(2'd1, 32'hAF, "outset_0f");
    wr(3'd5, 32'h81); expect_v(2'd1, 32'h2E, "outclr_81");
    rd(3'd4, 32'h0, "rd_outset");
    rd(3'd5, 32'h0, "rd_outclr");
    rd(3'd6, 32'h0, "rd_a6");
    rd(3'd7, 32'h0, "rd_a7");
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'hF0);
    expect_v(2'd2, 32'hF0, "oe_f0");
    in_port = 8'h03;
    step(); step(); step();
    rd(3'd0, 32'hF3, "mixed_f3");
    wr(3'd1, 32'hFFFF_FF0F);
    rd(3'd1, 32'h0F, "dir_upper_ignored");
    rd(3'd0, 32'h0F, "mixed_0f");
    wr(3'd6, 32'h00); wr(3'd7, 32'h00);
    expect_v(2'd1, 32'hFF, "a67_out_keep");
    expect_v(2'd2, 32'h0F, "a67_oe_keep");
    wr(3'd1, 32'h00);
`ifdef QLAB5_GPIO_EDGE_CAPTURE_EN
    rd(3'd3, 32'h03, "cap_initial");
    expect_v(2'd3, 32'h0, "irq_masked");
    wr(3'd2, 32'h01);
    rd(3'd2, 32'h01, "mask_rd");
    expect_v(2'd3, 32'h1, "irq_unmasked");
    wr(3'd3, 32'hFF);
    rd(3'd3, 32'h00, "cap_cleared");
    expect_v(2'd3, 32'h0, "irq_cleared");
    in_port = 8'h00;
    step(); step(); step();
    rd(3'd3, 32'h00, "fall_ignored");
    in_port = 8'h01;
    step(); expect_v(2'd3, 32'h0, "irq_e1");
    step(); expect_v(2'd3, 32'h0, "irq_e2");
    rd(3'd3, 32'h00, "cap_e2");
    expect_v(2'd3, 32'h1, "irq_e3");
    rd(3'd3, 32'h01, "cap_e3");
    wr(3'd3, 32'h01);
    expect_v(2'd3, 32'h0, "irq_w1c");
    in_port = 8'h00; step(); step(); step();
    in_port = 8'h01; step(); step(); step();
    expect_v(2'd3, 32'h1, "irq_reset_up");
    in_port = 8'h00; step(); step(); step();
    in_port = 8'h01; step(); step();
    wr(3'd3, 32'h01);
    expect_v(2'd3, 32'h1, "irq_set_wins");
    rd(3'd3, 32'h01, "cap_set_wins");
    wr(3'd3, 32'h01);
    expect_v(2'd3, 32'h0, "irq_after_clr");
`else
    in_port = 8'h00; step(); step(); step();
    in_port = 8'h01; step(); step(); step();
    rd(3'd3, 32'h0, "nocap_a3");
    wr(3'd2, 32'hFF);
    rd(3'd2, 32'h0, "nocap_a2");
    wr(3'd3, 32'hFF);
`endif
    in_port = 8'hFF;
    reset_n = 0;
    chipselect = 1; write_n = 0; address = 3'd0; writedata = 32'h33;
    step();
    chipselect = 0; write_n = 1;
    step();
    reset_n = 1;
    for (int i = 0; i < 10; i++) rd(3'd3, 32'h0, "blank_cap");
    expect_v(2'd1, 32'h5A, "rerst_out_port");
    expect_v(2'd2, 32'h00, "rerst_oe");
    expect_v(2'd3, 32'h0, "rerst_irq");
    rd(3'd0, 32'hFF, "rerst_mixed");
    @(negedge clk); #1;
    if (kq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d expected 0", kq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
